wb_master_arbiter: RTL and testbench

Two-master Wishbone arbiter that shares the single peripheral bus behind the SPI-to-Wishbone bridge with a second master (flight-control sequencer / soft CPU). It grants the bus per cycle (`cyc`) with round-robin fairness and holds the grant for the whole cycle, so SPI burst reads and writes are never interleaved. A bus watchdog aborts stalled transfers so a dead slave cannot hang either master.

---
 rtl/wb_master_arbiter.sv | 132 +++++++++++++
 tb/tb_wb_master_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter: round-robin grant held for a whole cycle,
// with a stalled-strobe watchdog that aborts the transfer with err.
module wb_master_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    s0_wb_cyc_i,
    input  logic                    s0_wb_stb_i,
    input  logic                    s0_wb_we_i,
    input  logic [ADDR_WIDTH-1:0]   s0_wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   s0_wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] s0_wb_sel_i,
    output logic [DATA_WIDTH-1:0]   s0_wb_dat_o,
    output logic                    s0_wb_ack_o,
    output logic                    s0_wb_err_o,
    input  logic                    s1_wb_cyc_i,
    input  logic                    s1_wb_stb_i,
    input  logic                    s1_wb_we_i,
    input  logic [ADDR_WIDTH-1:0]   s1_wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   s1_wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] s1_wb_sel_i,
    output logic [DATA_WIDTH-1:0]   s1_wb_dat_o,
    output logic                    s1_wb_ack_o,
    output logic                    s1_wb_err_o,
    output logic                    m_wb_cyc_o,
    output logic                    m_wb_stb_o,
    output logic                    m_wb_we_o,
    output logic [ADDR_WIDTH-1:0]   m_wb_adr_o,
    output logic [DATA_WIDTH-1:0]   m_wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] m_wb_sel_o,
    input  logic [DATA_WIDTH-1:0]   m_wb_dat_i,
    input  logic                    m_wb_ack_i,
    input  logic                    m_wb_err_i,
    output logic [1:0]              o_grant,
    output logic                    o_timeout
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;
    localparam logic [1:0] ABORT  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          first_q, first_d;

    logic g0, g1, ab, own_cyc, stall;

    assign g0 = (state_q == GRANT0);
    assign g1 = (state_q == GRANT1);
    assign ab = (state_q == ABORT);

    // last_q always names the current owner while granted or aborting
    assign own_cyc = last_q ? s1_wb_cyc_i : s0_wb_cyc_i;
    assign stall   = (g0 | g1) & m_wb_stb_o & ~m_wb_ack_i & ~m_wb_err_i;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = '0;
        first_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s0_wb_cyc_i && (!s1_wb_cyc_i || last_q)) begin
                    state_d = GRANT0;
                    last_d  = 1'b0;
                end else if (s1_wb_cyc_i) begin
                    state_d = GRANT1;
                    last_d  = 1'b1;
                end
            end
            GRANT0, GRANT1: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                end else if (stall) begin
                    if (TIMEOUT_CYCLES != 0 && cnt_q == TMAX) begin
                        state_d = ABORT;
                        first_d = 1'b1;
                    end else if (cnt_q != TMAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
            end
            ABORT: begin
                if (!own_cyc) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    // Bus side mirrors the owner; ABORT and IDLE leave it quiet
    assign m_wb_cyc_o = g0 ? s0_wb_cyc_i : (g1 ? s1_wb_cyc_i : 1'b0);
    assign m_wb_stb_o = g0 ? s0_wb_stb_i : (g1 ? s1_wb_stb_i : 1'b0);
    assign m_wb_we_o  = g0 ? s0_wb_we_i  : (g1 ? s1_wb_we_i  : 1'b0);
    assign m_wb_adr_o = g0 ? s0_wb_adr_i : (g1 ? s1_wb_adr_i : '0);
    assign m_wb_dat_o = g0 ? s0_wb_dat_i : (g1 ? s1_wb_dat_i : '0);
    assign m_wb_sel_o = g0 ? s0_wb_sel_i : (g1 ? s1_wb_sel_i : '0);

    assign s0_wb_dat_o = g0 ? m_wb_dat_i : '0;
    assign s1_wb_dat_o = g1 ? m_wb_dat_i : '0;
    assign s0_wb_ack_o = g0 & m_wb_ack_i;
    assign s1_wb_ack_o = g1 & m_wb_ack_i;
    assign s0_wb_err_o = (g0 & m_wb_err_i) | (ab & first_q & ~last_q);
    assign s1_wb_err_o = (g1 & m_wb_err_i) | (ab & first_q & last_q);

    assign o_timeout = ab & first_q;
    assign o_grant   = {g1 | (ab & last_q), g0 | (ab & ~last_q)};

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: vector table for grant/routing,
// hand sequences for reset, bursts and watchdog corners.
module tb_wb_master_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        c0, s0, we0, c1, s1, we1;
    logic [31:0] adr0, adr1, wd0, wd1, rd0, rd1;
    logic [3:0]  sel0, sel1;
    logic        a0, e0, a1, e1;
    logic        mcyc, mstb, mwe;
    logic [31:0] madr, mdo, mdi;
    logic [3:0]  msel;
    logic        mack, merr;
    logic [1:0]  gnt;
    logic        tmo;

    int nvec = 0;
    int nmis = 0;

    localparam logic [31:0] A0   = 32'hA0A0_0000;
    localparam logic [31:0] A1   = 32'hB1B1_0000;
    localparam logic [31:0] MDAT = 32'hD00D_F00D;

    always #5 clk = ~clk;

    wb_master_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .i_clk(clk), .i_reset(rst),
        .s0_wb_cyc_i(c0), .s0_wb_stb_i(s0), .s0_wb_we_i(we0),
        .s0_wb_adr_i(adr0), .s0_wb_dat_i(wd0), .s0_wb_sel_i(sel0),
        .s0_wb_dat_o(rd0), .s0_wb_ack_o(a0), .s0_wb_err_o(e0),
        .s1_wb_cyc_i(c1), .s1_wb_stb_i(s1), .s1_wb_we_i(we1),
        .s1_wb_adr_i(adr1), .s1_wb_dat_i(wd1), .s1_wb_sel_i(sel1),
        .s1_wb_dat_o(rd1), .s1_wb_ack_o(a1), .s1_wb_err_o(e1),
        .m_wb_cyc_o(mcyc), .m_wb_stb_o(mstb), .m_wb_we_o(mwe),
        .m_wb_adr_o(madr), .m_wb_dat_o(mdo), .m_wb_sel_o(msel),
        .m_wb_dat_i(mdi), .m_wb_ack_i(mack), .m_wb_err_i(merr),
        .o_grant(gnt), .o_timeout(tmo)
    );

    typedef struct packed {
        logic [5:0] in;   // c0 s0 c1 s1 ack err
        logic [1:0] g;
        logic [6:0] o;    // cyc stb a0 a1 e0 e1 tmo
        logic [1:0] src;  // 0 none, 1 master0, 2 master1
    } vec_t;

    function automatic vec_t v(input logic [5:0] i, input logic [1:0] g,
                               input logic [6:0] o, input logic [1:0] s);
        vec_t r;
        r.in = i; r.g = g; r.o = o; r.src = s;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t tbl[24];
        vec_t t;
        logic [7:0] bseq [6];
        logic [31:0] ea, ed0, ed1;

        bseq[0] = 8'h55; bseq[1] = 8'h44; bseq[2] = 8'h33;
        bseq[3] = 8'h22; bseq[4] = 8'h11; bseq[5] = 8'h00;

        tbl[0]  = v(6'b001110, 2'b00, 7'b0000000, 2'd0);
        tbl[1]  = v(6'b000000, 2'b10, 7'b0000000, 2'd2);
        tbl[2]  = v(6'b000000, 2'b00, 7'b0000000, 2'd0);
        tbl[3]  = v(6'b111100, 2'b00, 7'b0000000, 2'd0);
        tbl[4]  = v(6'b111110, 2'b01, 7'b1110000, 2'd1);
        tbl[5]  = v(6'b111110, 2'b01, 7'b1110000, 2'd1);
        tbl[6]  = v(6'b111110, 2'b01, 7'b1110000, 2'd1);
        tbl[7]  = v(6'b111110, 2'b01, 7'b1110000, 2'd1);
        tbl[8]  = v(6'b001100, 2'b01, 7'b0000000, 2'd1);
        tbl[9]  = v(6'b111100, 2'b00, 7'b0000000, 2'd0);
        tbl[10] = v(6'b111110, 2'b10, 7'b1101000, 2'd2);
        tbl[11] = v(6'b111110, 2'b10, 7'b1101000, 2'd2);
        tbl[12] = v(6'b111110, 2'b10, 7'b1101000, 2'd2);
        tbl[13] = v(6'b111110, 2'b10, 7'b1101000, 2'd2);
        tbl[14] = v(6'b110000, 2'b10, 7'b0000000, 2'd2);
        tbl[15] = v(6'b111100, 2'b00, 7'b0000000, 2'd0);
        tbl[16] = v(6'b111110, 2'b01, 7'b1110000, 2'd1);
        tbl[17] = v(6'b000000, 2'b01, 7'b0000000, 2'd1);
        tbl[18] = v(6'b000011, 2'b00, 7'b0000000, 2'd0);
        tbl[19] = v(6'b000000, 2'b00, 7'b0000000, 2'd0);
        tbl[20] = v(6'b001100, 2'b00, 7'b0000000, 2'd0);
        tbl[21] = v(6'b001101, 2'b10, 7'b1100010, 2'd2);
        tbl[22] = v(6'b000000, 2'b10, 7'b0000000, 2'd2);
        tbl[23] = v(6'b000000, 2'b00, 7'b0000000, 2'd0);

        rst = 1'b1;
        c0 = 1'b1; s0 = 1'b0; we0 = 1'b1; adr0 = A0; wd0 = 32'h1; sel0 = 4'hF;
        c1 = 1'b1; s1 = 1'b0; we1 = 1'b1; adr1 = A1; wd1 = 32'h2; sel1 = 4'hF;
        mdi = MDAT; mack = 1'b1; merr = 1'b1;

        // reset held 3 clocks with both masters requesting
        repeat (3) @(posedge clk);
        #2;
        chk("rst_grant", {30'd0, gnt}, 32'd0);
        chk("rst_mcyc", {31'd0, mcyc}, 32'd0);
        chk("rst_mstb", {31'd0, mstb}, 32'd0);
        chk("rst_mwe", {31'd0, mwe}, 32'd0);
        chk("rst_madr", madr, 32'd0);
        chk("rst_mdat", mdo, 32'd0);
        chk("rst_msel", {28'd0, msel}, 32'd0);
        chk("rst_ackerr", {28'd0, a0, e0, a1, e1}, 32'd0);
        chk("rst_rdat", rd0 | rd1, 32'd0);
        chk("rst_tmo", {31'd0, tmo}, 32'd0);
        rst = 1'b0; mack = 1'b0; merr = 1'b0;
        @(posedge clk);
        #2;
        chk("rst_first_grant", {30'd0, gnt}, 32'd1);
        chk("rst_first_mcyc", {31'd0, mcyc}, 32'd1);
        c0 = 1'b0; c1 = 1'b0;

        for (int i = 0; i < 24; i++) begin
            t = tbl[i];
            tick();
            {c0, s0, c1, s1, mack, merr} = t.in;
            #1;
            ea  = (t.src == 2'd1) ? A0 : ((t.src == 2'd2) ? A1 : 32'd0);
            ed0 = (t.src == 2'd1) ? MDAT : 32'd0;
            ed1 = (t.src == 2'd2) ? MDAT : 32'd0;
            chk($sformatf("v%0d_grant", i), {30'd0, gnt}, {30'd0, t.g});
            chk($sformatf("v%0d_outs", i),
                {25'd0, mcyc, mstb, a0, a1, e0, e1, tmo}, {25'd0, t.o});
            chk($sformatf("v%0d_madr", i), madr, ea);
            chk($sformatf("v%0d_rd0", i), rd0, ed0);
            chk($sformatf("v%0d_rd1", i), rd1, ed1);
        end

        // single read by master 0, slave acks one clock after stb
        tick();
        c0 = 1'b1; s0 = 1'b1; we0 = 1'b0; adr0 = 32'h1122_3344;
        tick();
        #1;
        chk("rd_grant", {30'd0, gnt}, 32'd1);
        chk("rd_madr", madr, 32'h1122_3344);
        chk("rd_mwe", {31'd0, mwe}, 32'd0);
        chk("rd_noack_yet", {31'd0, a0}, 32'd0);
        tick();
        mack = 1'b1; mdi = 32'hFFEE_DDCC;
        #1;
        chk("rd_ack0", {31'd0, a0}, 32'd1);
        chk("rd_dat0", rd0, 32'hFFEE_DDCC);
        chk("rd_ack1", {31'd0, a1}, 32'd0);
        chk("rd_dat1", rd1, 32'd0);
        tick();
        c0 = 1'b0; s0 = 1'b0; mack = 1'b0;
        tick();
        #1;
        chk("rd_release", {30'd0, gnt}, 32'd0);

        // 6-byte write burst by master 0; master 1 requests mid-burst
        tick();
        c0 = 1'b1; s0 = 1'b1; we0 = 1'b1; sel0 = 4'h1; wd0 = {24'd0, bseq[0]};
        mack = 1'b1;
        for (int b = 0; b < 6; b++) begin
            tick();
            wd0 = {24'd0, bseq[b]};
            if (b == 2) begin
                c1 = 1'b1; s1 = 1'b1;
            end
            #1;
            chk($sformatf("bl%0d_grant", b), {30'd0, gnt}, 32'd1);
            chk($sformatf("bl%0d_mdat", b), mdo, {24'd0, bseq[b]});
            chk($sformatf("bl%0d_acks", b), {30'd0, a0, a1}, 32'd2);
        end
        tick();
        c0 = 1'b0; s0 = 1'b0; mack = 1'b0;
        #1;
        chk("bl_drop_mcyc", {31'd0, mcyc}, 32'd0);
        tick();
        #1;
        chk("bl_dead_clock", {30'd0, gnt}, 32'd0);
        tick();
        #1;
        chk("bl_grant1", {30'd0, gnt}, 32'd2);
        chk("bl_grant1_mcyc", {31'd0, mcyc}, 32'd1);
        c1 = 1'b0; s1 = 1'b0;
        tick();
        #1;
        chk("bl_idle", {30'd0, gnt}, 32'd0);

        // slave never acks: watchdog aborts after the 9th stalled clock
        tick();
        c0 = 1'b1; s0 = 1'b1; we0 = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            #1;
            chk($sformatf("to_stall%0d", k), {29'd0, mcyc, e0, tmo}, 32'd4);
        end
        tick();
        #1;
        chk("to_fire", {28'd0, e0, tmo, mcyc, mstb}, 32'hC);
        chk("to_fire_e1", {31'd0, e1}, 32'd0);
        tick();
        #1;
        chk("to_after", {29'd0, e0, tmo, mcyc}, 32'd0);
        tick();
        mack = 1'b1;
        #1;
        chk("to_late_ack", {30'd0, a0, mcyc}, 32'd0);
        tick();
        mack = 1'b0; c0 = 1'b0; s0 = 1'b0;
        tick();
        #1;
        chk("to_idle", {29'd0, gnt, tmo}, 32'd0);

        // ack on the deciding stall clock wins over the timeout
        tick();
        c0 = 1'b1; s0 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            mack = (k == 8);
            #1;
            chk($sformatf("bd_beat%0d", k), {28'd0, a0, e0, tmo, mcyc},
                (k == 8) ? 32'h9 : 32'h1);
        end
        tick();
        mack = 1'b0;
        #1;
        chk("bd_after_ack", {28'd0, gnt, tmo, mcyc}, 32'h5);
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            chk($sformatf("bd_stall%0d", k), {30'd0, mcyc, e0}, 32'd2);
        end
        tick();
        c0 = 1'b0; s0 = 1'b0;
        #1;
        chk("bd_drop_err", {31'd0, e0}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            chk($sformatf("bd_idle%0d", k), {28'd0, gnt, e0, tmo}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
